// File: rtl/temptext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temptext_pkg
// Description : Shared field layout, FIFO entry type and status packing helper
//               for the TEMPTEXT byte-to-word packer.
//               text_word = {VALID, SEQ, NBYTES[1:0], LEVEL[3:0], PAYLOAD[23:0]}
// Revision    : 1.0 - initial release
// ============================================================================
package temptext_pkg;

    localparam int c_VALID_BIT   = 31;
    localparam int c_SEQ_BIT     = 30;
    localparam int c_NBYTES_LSB  = 28;
    localparam int c_NBYTES_W    = 2;
    localparam int c_LEVEL_LSB   = 24;
    localparam int c_LEVEL_W     = 4;
    localparam int c_PAYLOAD_LSB = 0;
    localparam int c_PAYLOAD_W   = 24;

    typedef struct packed {
        logic [1:0]  nbytes;
        logic [23:0] payload;
    } fifo_entry_t;

    // Assembles the full PIO word from its status fields and payload.
    function automatic logic [31:0] pack_status(
        input logic                   valid,
        input logic                   seq,
        input logic [c_NBYTES_W-1:0]  nbytes,
        input logic [c_LEVEL_W-1:0]   level,
        input logic [c_PAYLOAD_W-1:0] payload
    );
        logic [31:0] word;
        word = '0;
        word[c_VALID_BIT]                          = valid;
        word[c_SEQ_BIT]                            = seq;
        word[c_NBYTES_LSB +: c_NBYTES_W]           = nbytes;
        word[c_LEVEL_LSB +: c_LEVEL_W]             = level;
        word[c_PAYLOAD_LSB +: c_PAYLOAD_W]         = payload;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/temptext_fifo.sv
`default_nettype none
// ============================================================================
// Module      : temptext_fifo
// Description : Synchronous show-ahead FIFO of fifo_entry_t.
//               Ports: clk, reset (sync, active-high), i_push/i_push_data,
//               i_pop, o_head (current head, valid when !o_empty),
//               o_full, o_empty, o_level (occupancy 0..DEPTH).
// Revision    : 1.0 - initial release
// ============================================================================
module temptext_fifo
    import temptext_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  fifo_entry_t i_push_data,
    input  logic        i_pop,
    output fifo_entry_t o_head,
    output logic        o_full,
    output logic        o_empty,
    output logic [3:0]  o_level
);

    localparam int         c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_DEPTH_LVL = 4'(DEPTH);

    fifo_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [3:0]           r_level;
    logic                 w_push;
    logic                 w_pop;

    assign w_push = i_push && (r_level != c_DEPTH_LVL);
    assign w_pop  = i_pop  && (r_level != 4'd0);

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + {3'b000, w_push} - {3'b000, w_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == c_DEPTH_LVL);
    assign o_empty = (r_level == 4'd0);
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/temptext_packer.sv
`default_nettype none
// ============================================================================
// Module      : temptext_packer
// Description : Packs a valid/ready byte stream into 3-byte words, queues them
//               and presents the head word with status on a static 32-bit PIO
//               value. Software pops by writing the displayed SEQ bit back on
//               ack_toggle.
//               Ports: clk, reset (sync, active-high), in_data/in_valid/
//               in_ready (byte input), flush (push partial word),
//               ack_toggle (pop handshake), text_word (registered PIO value).
//               Build option: TEMPTEXT_TIMEOUT_EN enables auto-flush of a
//               partial word after TIMEOUT_CYCLES idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module temptext_packer
    import temptext_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        ack_toggle,
    output logic [31:0] text_word
);

    logic [1:0]          r_count;
    logic [23:0]         r_payload;
    logic                r_flush_pending;
    logic                r_seq;
    logic [31:0]         r_text_word;

    logic                w_accept;
    logic [1:0]          w_ins_count;
    logic [23:0]         w_ins_payload;
    logic                w_flush_req;
    logic                w_timeout;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_next_count;
    logic [23:0]         w_next_payload;
    logic                w_next_pending;
    fifo_entry_t         w_push_data;
    fifo_entry_t         w_head;
    logic                w_full;
    logic                w_empty;
    logic [3:0]          w_level;

    // A non-positive timeout is meaningless in either build.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_guard
    end

    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready;

    // Byte assembler: the incoming byte lands at lane r_count before any
    // push/flush decision, so a same-cycle flush includes it.
    always_comb begin
        w_ins_count   = r_count + {1'b0, w_accept};
        w_ins_payload = r_payload;
        if (w_accept) begin
            w_ins_payload[{r_count, 3'b000} +: 8] = in_data;
        end
    end

`ifdef TEMPTEXT_TIMEOUT_EN
    localparam int                 c_TMR_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_TMR_W-1:0] c_IDLE_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMR_W-1:0] r_idle;

    // Saturates at the terminal count so a timeout seen while the FIFO is
    // full keeps requesting until the pending flush drains the partial word.
    always_ff @(posedge clk) begin
        if (reset || w_accept || (r_count == 2'd0)) begin
            r_idle <= '0;
        end else if (r_idle != c_IDLE_LAST) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign w_timeout = (r_count != 2'd0) && (r_idle == c_IDLE_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_flush_req = flush || r_flush_pending || w_timeout;

    always_comb begin
        w_push         = 1'b0;
        w_next_count   = w_ins_count;
        w_next_payload = w_ins_payload;
        w_next_pending = 1'b0;
        w_push_data    = '{nbytes: w_ins_count, payload: w_ins_payload};
        if (w_ins_count == 2'd3) begin
            // A byte was accepted, so the FIFO has room; any flush folds in.
            w_push         = 1'b1;
            w_next_count   = 2'd0;
            w_next_payload = '0;
        end else if (w_flush_req && (w_ins_count != 2'd0)) begin
            if (!w_full) begin
                w_push         = 1'b1;
                w_next_count   = 2'd0;
                w_next_payload = '0;
            end else begin
                w_next_pending = 1'b1;
            end
        end
    end

    // Gate on the displayed VALID: once popped, SEQ flips and the stale
    // display cannot match again until software writes the new SEQ.
    assign w_pop = r_text_word[c_VALID_BIT] && (ack_toggle == r_seq) && !w_empty;

    temptext_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count         <= 2'd0;
            r_payload       <= '0;
            r_flush_pending <= 1'b0;
            r_seq           <= 1'b1;
            r_text_word     <= pack_status(1'b0, 1'b1, 2'd0, 4'd0, 24'd0);
        end else begin
            r_count         <= w_next_count;
            r_payload       <= w_next_payload;
            r_flush_pending <= w_next_pending;
            if (w_pop) begin
                r_seq <= ~r_seq;
            end
            if (w_empty) begin
                r_text_word <= pack_status(1'b0, r_seq, 2'd0, 4'd0, 24'd0);
            end else begin
                r_text_word <= pack_status(1'b1, r_seq, w_head.nbytes, w_level,
                                           w_head.payload);
            end
        end
    end

    assign text_word = r_text_word;

endmodule
`default_nettype wire
